// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, NZCV-style flags and a
// multi-cycle shift-add unsigned multiplier.
module alu_seq #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOT = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic accept;
  logic mul_start;
  logic mul_step;
  logic mul_done;
  logic is_mul;

  logic [CNTW-1:0]  cnt_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_nxt;

  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic             shift_oob;

  logic [WIDTH-1:0] ld_res;
  logic             ld_carry;
  logic             ld_ovf;

  assign is_mul = (op == OP_MUL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_done)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and handshake decode
  always_comb begin
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready  = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        mul_start = accept && is_mul;
      end
      ST_MUL: begin
        mul_step = 1'b1;
        mul_done = (cnt_q == CNTW'(WIDTH - 1));
      end
      default: ;
    endcase
  end

  // Single-cycle operation results
  always_comb begin
    res_c     = '0;
    carry_c   = 1'b0;
    ovf_c     = 1'b0;
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    shift_oob = (32'(b) >= WIDTH);
    case (op)
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_NOT: res_c = ~a;
      OP_ADD: begin
        res_c   = sum_w[WIDTH-1:0];
        carry_c = sum_w[WIDTH];
        ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = diff_w[WIDTH-1:0];
        carry_c = diff_w[WIDTH];
        ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: res_c = a ^ b;
      OP_SHL: res_c = shift_oob ? '0 : (a << b);
      OP_SHR: res_c = shift_oob ? '0 : (a >> b);
      default: res_c = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : PW'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (mul_start) begin
      cnt_q    <= '0;
      mcand_q  <= PW'(a);
      mplier_q <= b;
      acc_q    <= '0;
    end else if (mul_step) begin
      cnt_q    <= cnt_q + CNTW'(1);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_nxt;
    end
  end

  // Output register source: finished product or single-cycle result
  always_comb begin
    ld_res   = res_c;
    ld_carry = carry_c;
    ld_ovf   = ovf_c;
    if (mul_done) begin
      ld_res   = acc_nxt[WIDTH-1:0];
      ld_carry = 1'b0;
      ld_ovf   = |acc_nxt[PW-1:WIDTH];
    end
  end

  // Output registers; held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else if ((accept && !is_mul) || mul_done) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      carry     <= ld_carry;
      zero      <= (ld_res == '0);
      neg       <= ld_res[WIDTH-1];
      ovf       <= ld_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the original op encodings 000–100 and adds XOR, logical shifts and a multi-cycle shift-add multiply. It also adds a full NZCV-style flag set and valid/ready handshakes on input and output. It sits between an operand-issue stage and a writeback stage, and it can be backpressured.

Parameters:
WIDTH, 8, operand/result width in bits (legal: 2..32).
CNTW, $clog2(WIDTH)+1, width of the internal multiply iteration counter (derived; do not override).

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand/op presented.
in_ready  output  1  block can accept this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; shift amount for shift ops.
op  input  4  operation select.
out_valid  output  1  result/flags valid.
out_ready  input  1  downstream accepts result.
result  output  WIDTH  registered result.
carry  output  1  carry/borrow flag.
zero  output  1  result == 0.
neg  output  1  result[WIDTH-1].
ovf  output  1  signed overflow (ADD/SUB) or product overflow (MUL).

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, result=0, carry=0, zero=0, neg=0, ovf=0, counter=0, multiply registers cleared. Reset mid-multiply abandons the operation with no output.
- Accept: a transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Op encoding:
  - 0000 AND; 0001 OR; 0010 NOT A.
  - 0011 ADD. 0100 SUB (A−B).
  - 0101 XOR.
  - 0110 SHL by b; 0111 SHR (logical) by b.
  - 1000 MUL (unsigned).
  - 1001–1111 invalid: result=0, carry=0, ovf=0, zero=1, neg=0.
- Arithmetic rules:
  - ADD and SUB use (WIDTH+1)-bit unsigned arithmetic. carry = bit WIDTH of the sum or difference; for SUB this is a borrow, so 1 when A<B.
  - ovf for ADD/SUB is signed two's-complement overflow. It is 0 for all logic ops and shifts.
  - Shifts: if b >= WIDTH the result is 0. Shifts always set carry=0.
  - MUL: result = product[WIDTH-1:0]; ovf = |product[2*WIDTH-1:WIDTH]; carry=0.
  - zero and neg are always derived from the registered result.
- Single-cycle ops (all except MUL):
  - Output registers load on the accept edge; out_valid=1 the next cycle (latency 1).
  - Throughput is 1/cycle while out_ready=1.
- Multiply FSM:
  - IDLE → MUL on accept of op 1000. Latch a, b; clear the 2*WIDTH accumulator; counter=0; output registers are not written on this edge.
  - MUL: one shift-add step per cycle, WIDTH cycles total; in_ready=0.
  - On the step with counter==WIDTH-1: load result and flags, set out_valid=1, return to IDLE.
  - MUL latency: out_valid rises WIDTH+1 cycles after the accept edge.
- Output handshake:
  - result and flags are held stable while out_valid && !out_ready.
  - out_valid clears on a cycle with out_ready=1 unless a new single-cycle op is accepted in that same cycle. In that case the registers reload and out_valid stays 1.
  - If a MUL is accepted while the old result drains, out_valid falls the next cycle.
  - At MUL completion the output register is guaranteed empty; no overwrite is possible.
- in_valid while in_ready=0 is ignored; the source must hold its data. in_valid=0 causes no state change.

Test Plan:
1. WIDTH=8, ADD a=0xFF b=0x01 → next cycle out_valid=1, result=0x00, carry=1, zero=1, neg=0, ovf=0. ADD 0x7F+0x01 → 0x80, neg=1, ovf=1, carry=0.
2. SUB a=0x05 b=0x07 → result=0xFE, carry=1, neg=1, ovf=0. SUB 0x80−0x01 → 0x7F, ovf=1. Legacy ops: AND 0xF0,0x3C → 0x30; NOT 0x0F → 0xF0; op=1111 → result 0x00, zero=1.
3. MUL a=0x0C b=0x0B → in_ready=0 for 8 cycles; out_valid on cycle 9 after accept; result=0x84, ovf=0. MUL 0x10×0x10 → result=0x00, zero=1, ovf=1.
4. Backpressure: issue ADD, OR, XOR back-to-back with out_ready=0 for 3 cycles. Required: in_ready=0 after the first accept; result held at the ADD value; on release, results appear in order; none lost or duplicated.
5. Shifts: SHL 0x81 by 1 → 0x02, carry=0; SHR 0x80 by 7 → 0x01; SHL by 8 → 0x00, zero=1.
6. Assert rst at cycle 4 of a MUL → all outputs 0 immediately, in_ready=1 after release, no stale out_valid. A following ADD 0x01+0x02 → 0x03.
